// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and decoder state type.
// Used by both the display encoder and the receive-side decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } seg7_dec_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational {led, seg} -> value / legal / blank classifier.
// Tens LED adds 10 to digits 0-5; any other combination is illegal.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [7:0] i_word,
  output logic [3:0] o_value,
  output logic       o_legal,
  output logic       o_blank
);

  logic [6:0] w_seg;
  logic       w_led;
  logic [3:0] w_digit;
  logic       w_hit;

  assign w_seg = i_word[6:0];
  assign w_led = i_word[7];

  always_comb begin
    w_digit = 4'd0;
    w_hit   = 1'b1;
    unique case (1'b1)
      (w_seg == SEG_0): w_digit = 4'd0;
      (w_seg == SEG_1): w_digit = 4'd1;
      (w_seg == SEG_2): w_digit = 4'd2;
      (w_seg == SEG_3): w_digit = 4'd3;
      (w_seg == SEG_4): w_digit = 4'd4;
      (w_seg == SEG_5): w_digit = 4'd5;
      (w_seg == SEG_6): w_digit = 4'd6;
      (w_seg == SEG_7): w_digit = 4'd7;
      (w_seg == SEG_8): w_digit = 4'd8;
      (w_seg == SEG_9): w_digit = 4'd9;
      default:          w_hit   = 1'b0;
    endcase
  end

  assign o_blank = (w_seg == SEG_BLANK);
  assign o_legal = w_hit && (!w_led || (w_digit <= 4'd5));
  assign o_value = w_led ? (w_digit + 4'd10) : w_digit;

endmodule

// File: rtl/seg7_to_binary_decoder.sv
// Debounced 7-segment + tens-LED to binary decoder with valid/illegal pulses.
// Define SEG7_DEC_ERR_COUNT_EN to add the saturating err_count output.
module seg7_to_binary_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       led_in,
  output logic [3:0] binary_out,
  output logic       valid,
  output logic       illegal,
  output logic       busy
`ifdef SEG7_DEC_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (STABLE_CYCLES < 2 || ERR_CNT_W < 1) begin : g_bad_param
    $error("seg7_to_binary_decoder: bad parameter");
  end

  seg7_dec_state_t r_state, w_state_nxt;
  logic [7:0]      r_cand, w_cand_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_bin, w_bin_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_illegal, w_illegal_nxt;

  logic [7:0] w_word;
  logic [3:0] w_value;
  logic       w_legal;
  logic       w_blank;
  logic       w_same;
  logic       w_report;

  assign w_word = {led_in, seg_in};
  assign w_same = (w_word == r_cand);

  seg7_pattern_lookup u_lookup (
    .i_word  (w_word),
    .o_value (w_value),
    .o_legal (w_legal),
    .o_blank (w_blank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bin     <= w_bin_nxt;
      r_valid   <= w_valid_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_bin_nxt     = r_bin;
    w_valid_nxt   = 1'b0;
    w_illegal_nxt = 1'b0;
    w_report      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_blank) begin
          w_cand_nxt  = w_word;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_blank) begin
          w_state_nxt = IDLE;
        end else if (w_same) begin
          if (r_cnt == CNT_LAST) begin
            w_report    = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_cand_nxt = w_word;
          w_cnt_nxt  = CNT_ONE;
        end
      end
      HOLD: begin
        if (w_blank) begin
          w_state_nxt = IDLE;
        end else if (!w_same) begin
          w_cand_nxt  = w_word;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // At report time the sampled word equals the candidate, so decode w_word.
    if (w_report) begin
      if (w_legal) begin
        w_bin_nxt   = w_value;
        w_valid_nxt = 1'b1;
      end else begin
        w_illegal_nxt = 1'b1;
      end
    end
  end

  assign binary_out = r_bin;
  assign valid      = r_valid;
  assign illegal    = r_illegal;
  assign busy       = (r_state == SETTLE);

`ifdef SEG7_DEC_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_illegal_nxt && (r_err != '1)) begin
      r_err <= r_err + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err;
`endif

endmodule

// File: tb/tb_seg7_to_binary_decoder.sv
// Self-checking bench: run-length reference model plus directed scenarios.
// Build with SEG7_DEC_ERR_COUNT_EN to also check err_count.
module tb_seg7_to_binary_decoder;

  localparam int S   = 4;
  localparam int ECW = 8;

  localparam logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       led_in;
  logic [3:0] binary_out;
  logic       valid;
  logic       illegal;
  logic       busy;
`ifdef SEG7_DEC_ERR_COUNT_EN
  logic [ECW-1:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  seg7_to_binary_decoder #(
    .STABLE_CYCLES (S),
    .ERR_CNT_W     (ECW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .led_in     (led_in),
    .binary_out (binary_out),
    .valid      (valid),
    .illegal    (illegal),
    .busy       (busy)
`ifdef SEG7_DEC_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void decode(input logic [7:0] w, output bit legal,
                                 output logic [3:0] v);
    int d;
    d = -1;
    for (int i = 0; i < 10; i++)
      if (PAT[i] == w[6:0]) d = i;
    legal = (d >= 0) && (!w[7] || d <= 5);
    v = legal ? 4'(d + (w[7] ? 10 : 0)) : 4'd0;
  endfunction

  // Reference: a stable word is reported when its run of identical
  // non-blank samples reaches exactly S.
  logic [7:0] m_prev;
  int         m_run;
  logic [3:0] m_bin;
  bit         m_valid;
  bit         m_ill;
  int         m_err;

  always @(posedge clk) begin
    logic [7:0] w;
    bit         lg;
    logic [3:0] v;
    w = {led_in, seg_in};
    m_valid = 0;
    m_ill   = 0;
    if (!rst_n) begin
      m_run  = 0;
      m_bin  = 4'd0;
      m_err  = 0;
      m_prev = 8'd0;
    end else begin
      if (w[6:0] == 7'd0) m_run = 0;
      else if (m_run > 0 && w == m_prev) m_run = (m_run <= S) ? m_run + 1 : m_run;
      else m_run = 1;
      m_prev = w;
      if (m_run == S) begin
        decode(w, lg, v);
        if (lg) begin
          m_bin   = v;
          m_valid = 1;
        end else begin
          m_ill = 1;
          if (m_err < (1 << ECW) - 1) m_err++;
        end
      end
    end
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("binary_out", 32'(binary_out), 32'(m_bin));
    check("busy", 32'(busy), 32'(m_run >= 1 && m_run < S));
`ifdef SEG7_DEC_ERR_COUNT_EN
    check("err_count", 32'(err_count), 32'(m_err));
`endif
  end

  task automatic apply(input logic [7:0] w);
    @(negedge clk);
    {led_in, seg_in} = w;
  endtask

  // After apply(), the next posedge is the first sample; land on k+S-1.
  task automatic expect_report(input string nm, input bit ev, input bit ei,
                               input logic [3:0] eb);
    repeat (S) @(posedge clk);
    #2;
    check({nm, "_valid"}, 32'(valid), 32'(ev));
    check({nm, "_illegal"}, 32'(illegal), 32'(ei));
    check({nm, "_bin"}, 32'(binary_out), 32'(eb));
  endtask

  initial begin
    logic [7:0] w;
    int hold;
    rst_n  = 1'b0;
    seg_in = 7'($urandom);
    led_in = 1'($urandom);
    repeat (3) @(posedge clk);
    #2;
    check("rst_bin", 32'(binary_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    apply(8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("blank_idle_busy", 32'(busy), 32'd0);

    apply({1'b0, 7'b1011011});
    repeat (S - 1) @(posedge clk);
    #2;
    check("t2_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_bin", 32'(binary_out), 32'd5);
    repeat (4) @(posedge clk);
    #2;
    check("t2_no_repeat", 32'(valid), 32'd0);

    apply({1'b1, 7'b1111110});
    expect_report("t3a", 1, 0, 4'd10);
    repeat (2) @(posedge clk);
    apply({1'b1, 7'b1011011});
    expect_report("t3b", 1, 0, 4'd15);

    apply({1'b1, 7'b1111011});
    expect_report("t4", 0, 1, 4'd15);
`ifdef SEG7_DEC_ERR_COUNT_EN
    check("t4_err", 32'(err_count), 32'd1);
`endif
    repeat (2) @(posedge clk);

    apply({1'b0, 7'b0110000});
    repeat (1) @(negedge clk);
    apply({1'b0, 7'b1101101});
    expect_report("t5", 1, 0, 4'd2);
    repeat (2) @(posedge clk);

    apply({1'b0, 7'b1111001});
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_bin", 32'(binary_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_report("t6", 1, 0, 4'd3);
    repeat (2) @(posedge clk);

    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) w = {1'($urandom_range(0, 1)), PAT[$urandom_range(0, 9)]};
      else if (r < 65) w = {1'($urandom_range(0, 1)), 7'd0};
      else w = 8'($urandom);
      hold = $urandom_range(1, 7);
      apply(w);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (hold - 1) @(negedge clk);
    end

    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
